// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer write-side command engine.
package fb_pkg;

  localparam int unsigned FB_WIDTH_DEFAULT  = 360;
  localparam int unsigned FB_HEIGHT_DEFAULT = 240;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    OP_PIXEL = 2'd0,
    OP_FILL  = 2'd1,
    OP_FLIP  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT,
    S_FLIP_WAIT,
    S_FLIP
  } fb_state_e;

  // Exclusive end coordinate of a span, clipped to the screen edge.
  function automatic logic [10:0] clip_end(input logic [9:0] origin,
                                           input logic [9:0] extent,
                                           input int unsigned limit);
    logic [10:0] sum;
    sum = {1'b0, origin} + {1'b0, extent};
    return (sum > 11'(limit)) ? 11'(limit) : sum;
  endfunction

endpackage

// File: rtl/fb_raster_counter.sv
// Raster-order x/y/address stepper over a clipped rectangle; address advances
// incrementally so the fill loop needs no multiplier.
module fb_raster_counter #(
  parameter int unsigned FB_WIDTH = 360
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [9:0]  x_start,
  input  logic [9:0]  y_start,
  input  logic [19:0] addr_start,
  input  logic [10:0] x_end,
  input  logic [10:0] y_end,
  output logic [19:0] addr,
  output logic        last
);

  logic [9:0]  x, y, x0;
  logic [10:0] x_end_q, y_end_q;
  logic        row_end;

  always_comb begin
    row_end = ({1'b0, x} + 11'd1) == x_end_q;
    last    = row_end && (({1'b0, y} + 11'd1) == y_end_q);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      x       <= '0;
      y       <= '0;
      x0      <= '0;
      addr    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
    end else if (load) begin
      x       <= x_start;
      y       <= y_start;
      x0      <= x_start;
      addr    <= addr_start;
      x_end_q <= x_end;
      y_end_q <= y_end;
    end else if (step) begin
      if (row_end) begin
        // At wrap x = x_end-1: jump back (x_end-1-x0) and down one line.
        x    <= x0;
        y    <= y + 10'd1;
        addr <= addr + 20'(FB_WIDTH) + 20'd1 - 20'(x_end_q - {1'b0, x0});
      end else begin
        x    <= x + 10'd1;
        addr <= addr + 20'd1;
      end
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Command-driven pixel producer for the double-buffered framebuffer write side:
// single pixels, clipped rectangle fills and write-retired buffer flips.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH     = FB_WIDTH_DEFAULT,
  parameter int unsigned FB_HEIGHT    = FB_HEIGHT_DEFAULT,
  parameter int unsigned BUSY_HOLDOFF = 2,
  parameter int unsigned FLIP_PULSE   = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [15:0] cmd_color,
  output logic [19:0] display_addr,
  output logic [15:0] display_data,
  output logic        display_wr,
  output logic        display_flip_framebuffer,
  input  logic        display_busy,
  output logic        idle
);

  fb_state_e   state, state_next;
  logic [7:0]  cnt, cnt_next;
  rgb565_t     color;
  cmd_op_e     op;
  logic        accept, on_screen, load, step, last;
  logic [10:0] x_end_in, y_end_in;
  logic [19:0] addr_start;

  assign op = cmd_op_e'(cmd_op);

  always_comb begin
    on_screen  = (11'(cmd_x) < 11'(FB_WIDTH)) && (11'(cmd_y) < 11'(FB_HEIGHT));
    addr_start = 20'(cmd_y) * 20'(FB_WIDTH) + 20'(cmd_x);
    if (op == OP_FILL) begin
      x_end_in = clip_end(cmd_x, cmd_w, FB_WIDTH);
      y_end_in = clip_end(cmd_y, cmd_h, FB_HEIGHT);
    end else begin
      x_end_in = 11'(cmd_x) + 11'd1;
      y_end_in = 11'(cmd_y) + 11'd1;
    end
  end

  fb_raster_counter #(
    .FB_WIDTH(FB_WIDTH)
  ) u_raster (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load       (load),
    .step       (step),
    .x_start    (cmd_x),
    .y_start    (cmd_y),
    .addr_start (addr_start),
    .x_end      (x_end_in),
    .y_end      (y_end_in),
    .addr       (display_addr),
    .last       (last)
  );

  always_comb begin
    state_next               = state;
    cnt_next                 = cnt;
    load                     = 1'b0;
    step                     = 1'b0;
    accept                   = 1'b0;
    cmd_ready                = 1'b0;
    display_wr               = 1'b0;
    display_flip_framebuffer = 1'b0;
    idle                     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        idle      = !display_busy;
        accept    = cmd_valid;
        if (cmd_valid) begin
          case (op)
            OP_PIXEL: if (on_screen) begin
              load       = 1'b1;
              state_next = S_ISSUE;
            end
            OP_FILL: if (on_screen && cmd_w != '0 && cmd_h != '0) begin
              load       = 1'b1;
              state_next = S_ISSUE;
            end
            OP_FLIP: state_next = S_FLIP_WAIT;
            default: state_next = S_IDLE;
          endcase
        end
      end
      S_ISSUE: begin
        display_wr = 1'b1;
        cnt_next   = 8'(BUSY_HOLDOFF - 1);
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (cnt == '0) state_next = S_WAIT;
        else           cnt_next   = cnt - 8'd1;
      end
      S_WAIT: begin
        if (!display_busy) begin
          if (last) begin
            state_next = S_IDLE;
          end else begin
            step       = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_FLIP_WAIT: begin
        if (!display_busy) begin
          cnt_next   = 8'(FLIP_PULSE - 1);
          state_next = S_FLIP;
        end
      end
      S_FLIP: begin
        display_flip_framebuffer = 1'b1;
        if (cnt == '0) state_next = S_IDLE;
        else           cnt_next   = cnt - 8'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      color <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) color <= cmd_color;
    end
  end

  assign display_data = color;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: table vectors, hand sequences for
// busy pacing, flip and reset abort, and randomized commands against a raster model.
module tb_framebuffer_writer;

  localparam int W       = 360;
  localparam int H       = 240;
  localparam int HOLDOFF = 2;
  localparam int PULSE   = 4;
  localparam int OBS_MAX = 8192;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [15:0] cmd_color;
  logic [19:0] display_addr;
  logic [15:0] display_data;
  logic        display_wr;
  logic        display_flip_framebuffer;
  logic        display_busy = 1'b0;
  logic        idle;

  framebuffer_writer #(
    .FB_WIDTH     (W),
    .FB_HEIGHT    (H),
    .BUSY_HOLDOFF (HOLDOFF),
    .FLIP_PULSE   (PULSE)
  ) dut (
    .clk_sys                  (clk_sys),
    .reset_n                  (reset_n),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_op                   (cmd_op),
    .cmd_x                    (cmd_x),
    .cmd_y                    (cmd_y),
    .cmd_w                    (cmd_w),
    .cmd_h                    (cmd_h),
    .cmd_color                (cmd_color),
    .display_addr             (display_addr),
    .display_data             (display_data),
    .display_wr               (display_wr),
    .display_flip_framebuffer (display_flip_framebuffer),
    .display_busy             (display_busy),
    .idle                     (idle)
  );

  always #5 clk_sys = ~clk_sys;

  // Busy modes: 0 tied low, 1 pulse of pulse_len cycles after each strobe,
  // 2 random, 3 held high.
  int busy_mode = 0;
  int pulse_len = 5;
  logic wr_seen = 1'b0;

  always @(posedge clk_sys) begin
    static int busy_cnt = 0;
    #1;
    case (busy_mode)
      1: begin
        if (wr_seen) busy_cnt = pulse_len;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        display_busy = (busy_cnt > 0);
      end
      2: display_busy = ($urandom_range(0, 9) < 3);
      3: display_busy = 1'b1;
      default: begin
        busy_cnt     = 0;
        display_busy = 1'b0;
      end
    endcase
  end

  // Recorder and protocol monitor.
  logic [19:0] obs_addr [OBS_MAX];
  logic [15:0] obs_data [OBS_MAX];
  int obs_n = 0, flip_total = 0;
  int mon_checks = 0, mon_errors = 0;
  int cyc = 0, last_wr = -100, flip_run = 0;
  logic prev_flip = 1'b0, prev_busy = 1'b0;

  always @(negedge clk_sys) begin
    cyc++;
    wr_seen = display_wr && reset_n;
    if (!reset_n) begin
      last_wr   = -100;
      flip_run  = 0;
      prev_flip = 1'b0;
      prev_busy = display_busy;
    end else begin
      if (display_wr) begin
        if (obs_n < OBS_MAX) begin
          obs_addr[obs_n] = display_addr;
          obs_data[obs_n] = display_data;
        end
        obs_n++;
        mon_checks++;
        if (cyc - last_wr < HOLDOFF + 2) begin
          mon_errors++;
          $display("FAIL strobe_spacing: gap %0d cycles, required >= %0d", cyc - last_wr, HOLDOFF + 2);
        end
        last_wr = cyc;
        if (busy_mode == 1) begin
          mon_checks++;
          if (display_busy) begin
            mon_errors++;
            $display("FAIL strobe_while_busy: busy=%0b required 0 at cycle %0d", display_busy, cyc);
          end
        end
      end
      if (display_flip_framebuffer) begin
        if (!prev_flip) begin
          flip_total++;
          mon_checks++;
          if (prev_busy) begin
            mon_errors++;
            $display("FAIL flip_rise_busy: busy before rise=%0b required 0", prev_busy);
          end
        end
        flip_run++;
        mon_checks++;
        if (display_wr) begin
          mon_errors++;
          $display("FAIL flip_overlap: wr=%0b during flip required 0", display_wr);
        end
      end else if (prev_flip) begin
        mon_checks++;
        if (flip_run != PULSE) begin
          mon_errors++;
          $display("FAIL flip_length: high %0d cycles required %0d", flip_run, PULSE);
        end
        flip_run = 0;
      end
      prev_flip = display_flip_framebuffer;
      prev_busy = display_busy;
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: enumerate the clipped rectangle in raster order.
  int exp_addr[$];
  int exp_data[$];
  int exp_flips = 0;

  task automatic model_cmd(input int op, input int x, input int y, input int w, input int h, input int color);
    int xe, ye;
    if (op == 0 && x < W && y < H) begin
      exp_addr.push_back(y * W + x);
      exp_data.push_back(color);
    end else if (op == 1 && w > 0 && h > 0 && x < W && y < H) begin
      xe = (x + w > W) ? W : x + w;
      ye = (y + h > H) ? H : y + h;
      for (int yy = y; yy < ye; yy++)
        for (int xx = x; xx < xe; xx++) begin
          exp_addr.push_back(yy * W + xx);
          exp_data.push_back(color);
        end
    end else if (op == 2) begin
      exp_flips++;
    end
  endtask

  task automatic compare_model(input string name, input int base);
    int n;
    n = obs_n - base;
    chk({name, "_count"}, n, exp_addr.size());
    for (int i = 0; i < n && i < exp_addr.size() && base + i < OBS_MAX; i++) begin
      chk({name, "_addr"}, obs_addr[base + i], exp_addr[i]);
      chk({name, "_data"}, obs_data[base + i], exp_data[i]);
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic send(input int op, input int x, input int y, input int w, input int h, input int color);
    bit done;
    done = 1'b0;
    @(posedge clk_sys);
    #1;
    cmd_op    = 2'(op);
    cmd_x     = 10'(x);
    cmd_y     = 10'(y);
    cmd_w     = 10'(w);
    cmd_h     = 10'(h);
    cmd_color = 16'(color);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk_sys);
      if (cmd_ready) begin
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      cmd_valid = 1'b0;
      chk("cmd_accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk_sys);
      if (cmd_ready) done = 1'b1;
    end
    if (!done) chk("cmd_done_timeout", 0, 1);
  endtask

  typedef struct {
    string name;
    int op, x, y, w, h, color;
    int n_wr, first, n_flip;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int base, fbase;
    bit seen;

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;

    vecs.push_back('{"pixel_10_2",      0,  10,   2, 0, 0, 16'hF800, 1,   730, 0});
    vecs.push_back('{"fill_clip_right", 1, 358,   0, 4, 2, 16'h07E0, 4,   358, 0});
    vecs.push_back('{"fill_w0",         1,   5,   5, 0, 3, 16'h1111, 0,     0, 0});
    vecs.push_back('{"pixel_x400",      0, 400,   3, 0, 0, 16'h2222, 0,     0, 0});
    vecs.push_back('{"pixel_corner",    0, 359, 239, 0, 0, 16'hFFFF, 1, 86399, 0});
    vecs.push_back('{"fill_clip_bot",   1,   0, 239, 3, 5, 16'h1234, 3, 86040, 0});
    vecs.push_back('{"fill_y_off",      1,   0, 240, 2, 2, 16'h3333, 0,     0, 0});
    vecs.push_back('{"fill_3x2",        1,   0,   0, 3, 2, 16'h5A5A, 6,     0, 0});
    vecs.push_back('{"reserved_op",     3,   1,   1, 1, 1, 16'h4444, 0,     0, 0});
    vecs.push_back('{"flip",            2,   0,   0, 0, 0, 16'h0000, 0,     0, 1});

    repeat (3) @(negedge clk_sys);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_wr", display_wr, 0);
    chk("reset_flip", display_flip_framebuffer, 0);
    chk("reset_addr", display_addr, 0);
    chk("reset_data", display_data, 0);
    chk("reset_idle", idle, 1);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    foreach (vecs[i]) begin
      base  = obs_n;
      fbase = flip_total;
      exp_flips = 0;
      model_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
      send(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
      wait_done();
      repeat (2) @(negedge clk_sys);
      chk({vecs[i].name, "_nwr"}, obs_n - base, vecs[i].n_wr);
      if (vecs[i].n_wr > 0) chk({vecs[i].name, "_first"}, obs_addr[base], vecs[i].first);
      chk({vecs[i].name, "_flips"}, flip_total - fbase, vecs[i].n_flip);
      chk({vecs[i].name, "_model_flips"}, flip_total - fbase, exp_flips);
      chk({vecs[i].name, "_idle"}, idle, 1);
      compare_model(vecs[i].name, base);
    end

    // Dropped commands return ready quickly.
    send(1, 7, 7, 0, 4, 16'h0001);
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      @(negedge clk_sys);
      if (cmd_ready) seen = 1'b1;
    end
    chk("drop_ready_fast", seen, 1);

    // Pacing against a busy pulse after every strobe.
    busy_mode = 1;
    pulse_len = 5;
    base = obs_n;
    model_cmd(1, 20, 10, 3, 1, 16'hABCD);
    send(1, 20, 10, 3, 1, 16'hABCD);
    wait_done();
    compare_model("busy_fill", base);

    // Fill then flip with a longer busy tail.
    pulse_len = 6;
    base  = obs_n;
    fbase = flip_total;
    model_cmd(1, 100, 50, 2, 2, 16'hC0DE);
    send(1, 100, 50, 2, 2, 16'hC0DE);
    send(2, 0, 0, 0, 0, 0);
    wait_done();
    repeat (8) @(negedge clk_sys);
    compare_model("fill_then_flip", base);
    chk("fill_then_flip_count", flip_total - fbase, 1);

    // Flip must stay low while busy is held.
    busy_mode = 3;
    repeat (2) @(negedge clk_sys);
    fbase = flip_total;
    send(2, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk_sys);
    chk("flip_held_off", display_flip_framebuffer, 0);
    chk("flip_wait_not_idle", idle, 0);
    busy_mode = 0;
    wait_done();
    repeat (2) @(negedge clk_sys);
    chk("flip_after_busy", flip_total - fbase, 1);

    // Reset mid-fill aborts at once.
    base = obs_n;
    send(1, 0, 0, 4, 2, 16'h7777);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_sys);
      if (obs_n - base >= 3) seen = 1'b1;
    end
    chk("reset_fill_reached3", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_wr", display_wr, 0);
    chk("abort_flip", display_flip_framebuffer, 0);
    chk("abort_addr", display_addr, 0);
    chk("abort_ready", cmd_ready, 1);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("abort_idle", idle, 1);
    repeat (20) @(negedge clk_sys);
    chk("abort_no_more_wr", obs_n - base, 3);
    exp_addr.delete();
    exp_data.delete();
    base = obs_n;
    model_cmd(0, 5, 1, 0, 0, 16'h0F0F);
    send(0, 5, 1, 0, 0, 16'h0F0F);
    wait_done();
    compare_model("post_reset_pixel", base);
    chk("post_reset_addr", obs_addr[base], 365);

    // Reset mid-flip drops the line.
    send(2, 0, 0, 0, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk_sys);
      if (display_flip_framebuffer) seen = 1'b1;
    end
    chk("flip_seen_before_reset", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_flip_line", display_flip_framebuffer, 0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Randomized commands near the clip edges with random busy.
    busy_mode = 2;
    for (int n = 0; n < 25; n++) begin
      int op, x, y, w, h, color;
      op    = $urandom_range(0, 3);
      x     = $urandom_range(0, 1) ? $urandom_range(W - 6, W + 2) : $urandom_range(0, W - 1);
      y     = $urandom_range(0, 1) ? $urandom_range(H - 4, H + 1) : $urandom_range(0, H - 1);
      w     = $urandom_range(0, 8);
      h     = $urandom_range(0, 6);
      color = $urandom_range(0, 65535);
      base  = obs_n;
      fbase = flip_total;
      exp_flips = 0;
      model_cmd(op, x, y, w, h, color);
      send(op, x, y, w, h, color);
      wait_done();
      repeat (2) @(negedge clk_sys);
      compare_model("rand", base);
      chk("rand_flips", flip_total - fbase, exp_flips);
    end
    busy_mode = 0;
    repeat (4) @(negedge clk_sys);

    errors += mon_errors;
    checks += mon_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
